// File: rtl/alu_ctrl_core.sv
// Decode, one-stage ALU and branch resolution: CtrlD is combinational, the ALU uses the registered
// ALUControlE, and the branch decision is valid two edges after decode. There is no backpressure; BubbleD inserts a NOP.
module alu_ctrl_core (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [5:0]  OpD,
  input  logic [5:0]  FunctD,
  input  logic        BubbleD,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  output logic [18:0] CtrlD,
  output logic [31:0] ALUOutE,
  output logic [2:0]  ALUFlagE,
  output logic        ZeroM,
  output logic        PCSrcBranchM
);

  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010,
                         ALU_ADDU = 4'b0011, ALU_XOR  = 4'b0100, ALU_NOR  = 4'b0101,
                         ALU_SUB  = 4'b0110, ALU_SUBU = 4'b0111, ALU_SLT  = 4'b1000,
                         ALU_SLL  = 4'b1001, ALU_SRL  = 4'b1010, ALU_SRA  = 4'b1011,
                         ALU_LUI  = 4'b1100, ALU_PASSA = 4'b1101;

  localparam logic [18:0] RW = 19'd1 << 4,  MR = 19'd1 << 5,  MW = 19'd1 << 6,
                          BR = 19'd1 << 7,  BE = 19'd1 << 8,  AS = 19'd1 << 9,
                          RD = 19'd1 << 10, IS = 19'd1 << 11, IE = 19'd1 << 12,
                          SA = 19'd1 << 13, SB = 19'd1 << 14, JP = 19'd1 << 15,
                          JR = 19'd1 << 16, RJ = 19'd1 << 17, R1 = 19'd1 << 18;

  function automatic logic [18:0] alu_f(input logic [3:0] code);
    return {15'd0, code};
  endfunction

  always_comb begin
    CtrlD = '0;
    case (OpD)
      6'h00: begin
        case (FunctD)
          6'h20: CtrlD = alu_f(ALU_ADD)  | RW | RD;
          6'h21: CtrlD = alu_f(ALU_ADDU) | RW | RD;
          6'h22: CtrlD = alu_f(ALU_SUB)  | RW | RD;
          6'h23: CtrlD = alu_f(ALU_SUBU) | RW | RD;
          6'h24: CtrlD = alu_f(ALU_AND)  | RW | RD;
          6'h25: CtrlD = alu_f(ALU_OR)   | RW | RD;
          6'h26: CtrlD = alu_f(ALU_XOR)  | RW | RD;
          6'h27: CtrlD = alu_f(ALU_NOR)  | RW | RD;
          6'h2A: CtrlD = alu_f(ALU_SLT)  | RW | RD;
          6'h00: CtrlD = alu_f(ALU_SLL)  | RW | RD | IS | AS | SA;
          6'h02: CtrlD = alu_f(ALU_SRL)  | RW | RD | IS | AS | SA;
          6'h03: CtrlD = alu_f(ALU_SRA)  | RW | RD | IS | AS | SA;
          6'h04: CtrlD = alu_f(ALU_SLL)  | RW | RD | SA | SB;
          6'h06: CtrlD = alu_f(ALU_SRL)  | RW | RD | SA | SB;
          6'h07: CtrlD = alu_f(ALU_SRA)  | RW | RD | SA | SB;
          6'h08: CtrlD = JP | JR;
          default: CtrlD = '0;
        endcase
      end
      6'h08: CtrlD = alu_f(ALU_ADD)  | AS | RW;
      6'h09: CtrlD = alu_f(ALU_ADDU) | AS | RW;
      6'h0C: CtrlD = alu_f(ALU_AND)  | AS | IE | RW;
      6'h0D: CtrlD = alu_f(ALU_OR)   | AS | IE | RW;
      6'h0E: CtrlD = alu_f(ALU_XOR)  | AS | IE | RW;
      6'h0F: CtrlD = alu_f(ALU_LUI)  | AS | IE | RW;
      6'h23: CtrlD = alu_f(ALU_ADD)  | AS | MR | RW;
      6'h2B: CtrlD = alu_f(ALU_ADD)  | AS | MW;
      6'h04: CtrlD = alu_f(ALU_SUB)  | BR | BE;
      6'h05: CtrlD = alu_f(ALU_SUB)  | BR;
      6'h02: CtrlD = JP;
      6'h03: CtrlD = alu_f(ALU_PASSA) | JP | RW | RJ | R1;
      default: CtrlD = '0;
    endcase
  end

  logic [3:0] alu_control_e;
  logic       branch_e, branch_equal_e;
  logic       branch_m, branch_equal_m;
  logic [4:0] shamt;
  logic       ovf;

  assign shamt = SrcBE[4:0];

  always_comb begin
    ALUOutE = '0;
    ovf     = 1'b0;
    case (alu_control_e)
      ALU_AND:   ALUOutE = SrcAE & SrcBE;
      ALU_OR:    ALUOutE = SrcAE | SrcBE;
      ALU_ADD:   ALUOutE = SrcAE + SrcBE;
      ALU_ADDU:  ALUOutE = SrcAE + SrcBE;
      ALU_XOR:   ALUOutE = SrcAE ^ SrcBE;
      ALU_NOR:   ALUOutE = ~(SrcAE | SrcBE);
      ALU_SUB:   ALUOutE = SrcAE - SrcBE;
      ALU_SUBU:  ALUOutE = SrcAE - SrcBE;
      ALU_SLT:   ALUOutE = {31'd0, $signed(SrcAE) < $signed(SrcBE)};
      ALU_SLL:   ALUOutE = SrcAE << shamt;
      ALU_SRL:   ALUOutE = SrcAE >> shamt;
      ALU_SRA:   ALUOutE = $unsigned($signed(SrcAE) >>> shamt);
      ALU_LUI:   ALUOutE = {SrcBE[15:0], 16'd0};
      ALU_PASSA: ALUOutE = SrcAE;
      default:   ALUOutE = '0;
    endcase
    // Only the trapping-style ops report signed overflow; the U variants wrap silently.
    if (alu_control_e == ALU_ADD)
      ovf = (SrcAE[31] == SrcBE[31]) && (ALUOutE[31] != SrcAE[31]);
    else if (alu_control_e == ALU_SUB)
      ovf = (SrcAE[31] != SrcBE[31]) && (ALUOutE[31] != SrcAE[31]);
  end

  assign ALUFlagE = {ALUOutE == 32'd0, ALUOutE[31], ovf};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alu_control_e  <= '0;
      branch_e       <= 1'b0;
      branch_equal_e <= 1'b0;
    end else if (BubbleD) begin
      alu_control_e  <= '0;
      branch_e       <= 1'b0;
      branch_equal_e <= 1'b0;
    end else begin
      alu_control_e  <= CtrlD[3:0];
      branch_e       <= CtrlD[7];
      branch_equal_e <= CtrlD[8];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ZeroM          <= 1'b0;
      branch_m       <= 1'b0;
      branch_equal_m <= 1'b0;
    end else begin
      ZeroM          <= ALUFlagE[2];
      branch_m       <= branch_e;
      branch_equal_m <= branch_equal_e;
    end
  end

  assign PCSrcBranchM = branch_m & (branch_equal_m ? ZeroM : ~ZeroM);

endmodule

// File: tb/tb_alu_ctrl_core.sv
// Scoreboard bench for alu_ctrl_core: decode table sweep, ALU vectors, branch/bubble/reset scenarios.
module tb_alu_ctrl_core;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [5:0]  OpD, FunctD;
  logic        BubbleD;
  logic [31:0] SrcAE, SrcBE;
  logic [18:0] CtrlD;
  logic [31:0] ALUOutE;
  logic [2:0]  ALUFlagE;
  logic        ZeroM, PCSrcBranchM;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [63:0] sb[$];

  alu_ctrl_core dut (
    .CLK(CLK), .RST_N(RST_N), .OpD(OpD), .FunctD(FunctD), .BubbleD(BubbleD),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .CtrlD(CtrlD), .ALUOutE(ALUOutE),
    .ALUFlagE(ALUFlagE), .ZeroM(ZeroM), .PCSrcBranchM(PCSrcBranchM)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [18:0] RW = 19'd1 << 4,  MR = 19'd1 << 5,  MW = 19'd1 << 6,
                          BR = 19'd1 << 7,  BE = 19'd1 << 8,  AS = 19'd1 << 9,
                          RD = 19'd1 << 10, IS = 19'd1 << 11, IE = 19'd1 << 12,
                          SA = 19'd1 << 13, SB = 19'd1 << 14, JP = 19'd1 << 15,
                          JR = 19'd1 << 16, RJ = 19'd1 << 17, R1 = 19'd1 << 18;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] got);
    logic [63:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      chk(tag, got, exp);
    end
  endtask

  typedef struct { logic [5:0] op; logic [5:0] fn; logic [18:0] ctrl; string name; } dec_t;
  dec_t dec_tab[$];

  task automatic add_dec(input logic [5:0] op, input logic [5:0] fn, input logic [18:0] c, input string n);
    dec_t d;
    d.op = op; d.fn = fn; d.ctrl = c; d.name = n;
    dec_tab.push_back(d);
  endtask

  // ALU vector: decode op in D, clock into E, then apply operands and check out/flags.
  task automatic alu_vec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input logic [2:0] exp_flg);
    @(negedge CLK);
    OpD = op; FunctD = fn; BubbleD = 1'b0;
    sb.push_back({29'd0, exp_flg, exp_out});
    @(posedge CLK); #1;
    OpD = 6'h3F; SrcAE = a; SrcBE = b;
    #1;
    pop_chk(tag, {29'd0, ALUFlagE, ALUOutE});
  endtask

  // Branch: in D at edge 1, operands during E, decision after edge 2, gone after edge 3.
  task automatic br_vec(input string tag, input logic [5:0] op, input logic bub,
                        input logic [31:0] a, input logic [31:0] b, input logic exp_br);
    @(negedge CLK);
    OpD = op; FunctD = 6'h00; BubbleD = bub;
    sb.push_back({63'd0, exp_br});
    @(posedge CLK); #1;
    OpD = 6'h3F; BubbleD = 1'b0; SrcAE = a; SrcBE = b;
    #1;
    if (bub) chk({tag, "_bubble_and"}, {32'd0, ALUOutE}, {32'd0, a & b});
    @(posedge CLK); #1;
    pop_chk(tag, {63'd0, PCSrcBranchM});
    @(posedge CLK); #1;
    chk({tag, "_one_cycle"}, {63'd0, PCSrcBranchM}, 64'd0);
  endtask

  initial begin
    RST_N = 1'b0; OpD = 6'h3F; FunctD = 6'h00; BubbleD = 1'b0;
    SrcAE = 32'h0000_00F0; SrcBE = 32'h0000_003C;
    #12;
    chk("rst_zerom", {63'd0, ZeroM}, 64'd0);
    chk("rst_pcsrc", {63'd0, PCSrcBranchM}, 64'd0);
    chk("rst_alu_and", {32'd0, ALUOutE}, 64'h30);
    OpD = 6'h23;
    #1;
    chk("rst_ctrl_comb", {45'd0, CtrlD}, {45'd0, 19'd2 | AS | MR | RW});
    @(negedge CLK); RST_N = 1'b1;

    add_dec(6'h00, 6'h20, 19'd2  | RW | RD, "add");
    add_dec(6'h00, 6'h21, 19'd3  | RW | RD, "addu");
    add_dec(6'h00, 6'h22, 19'd6  | RW | RD, "sub");
    add_dec(6'h00, 6'h23, 19'd7  | RW | RD, "subu");
    add_dec(6'h00, 6'h24, 19'd0  | RW | RD, "and");
    add_dec(6'h00, 6'h25, 19'd1  | RW | RD, "or");
    add_dec(6'h00, 6'h26, 19'd4  | RW | RD, "xor");
    add_dec(6'h00, 6'h27, 19'd5  | RW | RD, "nor");
    add_dec(6'h00, 6'h2A, 19'd8  | RW | RD, "slt");
    add_dec(6'h00, 6'h00, 19'd9  | RW | RD | IS | AS | SA, "sll");
    add_dec(6'h00, 6'h02, 19'd10 | RW | RD | IS | AS | SA, "srl");
    add_dec(6'h00, 6'h03, 19'd11 | RW | RD | IS | AS | SA, "sra");
    add_dec(6'h00, 6'h04, 19'd9  | RW | RD | SA | SB, "sllv");
    add_dec(6'h00, 6'h06, 19'd10 | RW | RD | SA | SB, "srlv");
    add_dec(6'h00, 6'h07, 19'd11 | RW | RD | SA | SB, "srav");
    add_dec(6'h00, 6'h08, JP | JR, "jr");
    add_dec(6'h00, 6'h01, 19'd0, "rbad");
    add_dec(6'h08, 6'h00, 19'd2  | AS | RW, "addi");
    add_dec(6'h09, 6'h00, 19'd3  | AS | RW, "addiu");
    add_dec(6'h0C, 6'h00, 19'd0  | AS | IE | RW, "andi");
    add_dec(6'h0D, 6'h00, 19'd1  | AS | IE | RW, "ori");
    add_dec(6'h0E, 6'h00, 19'd4  | AS | IE | RW, "xori");
    add_dec(6'h0F, 6'h00, 19'd12 | AS | IE | RW, "lui");
    add_dec(6'h23, 6'h00, 19'd2  | AS | MR | RW, "lw");
    add_dec(6'h2B, 6'h00, 19'd2  | AS | MW, "sw");
    add_dec(6'h04, 6'h00, 19'd6  | BR | BE, "beq");
    add_dec(6'h05, 6'h00, 19'd6  | BR, "bne");
    add_dec(6'h02, 6'h00, JP, "j");
    add_dec(6'h03, 6'h00, 19'd13 | JP | RW | RJ | R1, "jal");
    add_dec(6'h3F, 6'h20, 19'd0, "op3f");

    foreach (dec_tab[i]) begin
      OpD = dec_tab[i].op; FunctD = dec_tab[i].fn;
      sb.push_back({45'd0, dec_tab[i].ctrl});
      #1;
      pop_chk({"dec_", dec_tab[i].name}, {45'd0, CtrlD});
    end

    alu_vec("add_ovf",  6'h08, 6'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b011);
    alu_vec("addu_nov", 6'h09, 6'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b010);
    alu_vec("sub_zero", 6'h00, 6'h22, 32'd5, 32'd5, 32'h0, 3'b100);
    alu_vec("sub_ovf",  6'h00, 6'h22, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 3'b001);
    alu_vec("subu_wrap",6'h00, 6'h23, 32'h0, 32'h1, 32'hFFFF_FFFF, 3'b010);
    alu_vec("slt_neg",  6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1, 32'h1, 3'b000);
    alu_vec("slt_pos",  6'h00, 6'h2A, 32'h1, 32'hFFFF_FFFF, 32'h0, 3'b100);
    alu_vec("sra",      6'h00, 6'h03, 32'h8000_0000, 32'd4, 32'hF800_0000, 3'b010);
    alu_vec("srl",      6'h00, 6'h02, 32'h8000_0000, 32'h24, 32'h0800_0000, 3'b000);
    alu_vec("sllv",     6'h00, 6'h04, 32'h0000_0003, 32'd31, 32'h8000_0000, 3'b010);
    alu_vec("lui",      6'h0F, 6'h00, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 3'b000);
    alu_vec("nor",      6'h00, 6'h27, 32'h0, 32'h0, 32'hFFFF_FFFF, 3'b010);
    alu_vec("xori",     6'h0E, 6'h00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'b000);
    alu_vec("ori",      6'h0D, 6'h00, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 3'b000);
    alu_vec("jal_passa",6'h03, 6'h00, 32'h0040_0010, 32'h5555_5555, 32'h0040_0010, 3'b000);

    br_vec("beq_taken",  6'h04, 1'b0, 32'd7, 32'd7, 1'b1);
    br_vec("beq_not",    6'h04, 1'b0, 32'd7, 32'd8, 1'b0);
    br_vec("bne_equal",  6'h05, 1'b0, 32'd7, 32'd7, 1'b0);
    br_vec("bne_taken",  6'h05, 1'b0, 32'd7, 32'd8, 1'b1);
    br_vec("beq_bubble", 6'h04, 1'b1, 32'd7, 32'd7, 1'b0);

    // Reset between E and M edges of a taken beq.
    @(negedge CLK);
    OpD = 6'h04; BubbleD = 1'b0;
    @(posedge CLK); #1;
    OpD = 6'h3F; SrcAE = 32'd7; SrcBE = 32'd7;
    @(negedge CLK);
    RST_N = 1'b0; #1;
    chk("rst_mid_pcsrc", {63'd0, PCSrcBranchM}, 64'd0);
    chk("rst_mid_alu_and", {32'd0, ALUOutE}, 64'd7);
    @(posedge CLK); #1;
    chk("rst_hold_pcsrc", {63'd0, PCSrcBranchM}, 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_rel_pcsrc", {63'd0, PCSrcBranchM}, 64'd0);

    // Reset while a taken decision is visible clears it immediately.
    @(negedge CLK);
    OpD = 6'h04;
    @(posedge CLK); #1;
    OpD = 6'h3F; SrcAE = 32'd9; SrcBE = 32'd9;
    @(posedge CLK); #1;
    chk("taken_before_rst", {63'd0, PCSrcBranchM}, 64'd1);
    RST_N = 1'b0; #1;
    chk("rst_async_pcsrc", {63'd0, PCSrcBranchM}, 64'd0);
    chk("rst_async_zerom", {63'd0, ZeroM}, 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_async_after", {63'd0, PCSrcBranchM}, 64'd0);

    chk("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
